uart_tx: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the team's uart_rx at 9600 baud.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte LSB-first with one start bit and one stop bit.
- Exposes baud debug taps matching the receive path, so both ends can be probed on the same header.

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a small byte FIFO feeds an LSB-first serialiser.
// Baud debug taps (obaud_clk/obaud_cnt) mirror the receive path for probing.
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int BAUD_DIV = CLK_FREQ / BAUD,
  parameter int CNT_W    = 13,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic             obaud_clk,
  output logic [CNT_W-1:0] obaud_cnt
);

  localparam int               PW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(BAUD_DIV - 1);
  localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_q;
  logic [7:0]       shift_q;
  logic [2:0]       idx_q;

  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_end;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Fullness is judged before any same-cycle pop, so a full FIFO refuses a push.
  assign push    = tx_valid && !full;
  assign bit_end = (state_q != IDLE) && (cnt_q == LAST);
  // The FSM takes a byte when leaving IDLE or at the end of a stop bit.
  assign pop     = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  assign tx_ready  = !full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !empty;
  assign obaud_clk = bit_end;
  assign obaud_cnt = cnt_q;

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage; contents are irrelevant once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and count; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Serialiser FSM with baud counter; the byte is captured at pop so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      if ((state_q == IDLE) || bit_end) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!empty) begin
            shift_q <= mem_q[rd_ptr_q];
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!empty) begin
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at 16 clocks per bit. A frame-level reference model
// (byte queue + position within a 10-bit frame) predicts every output each cycle.
module tb_uart_tx;

  localparam int D     = 16;
  localparam int FL    = 10 * D;
  localparam int DEPTH = 4;
  localparam int CNT_W = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx;
  logic             busy;
  logic             obaud_clk;
  logic [CNT_W-1:0] obaud_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] fifo_m[$];
  logic [7:0] stim_q[$];
  int         pos = -1;
  logic [7:0] cur = 8'h00;
  int         pulses = 0;

  uart_tx #(
    .CLK_FREQ(16),
    .BAUD(1),
    .CNT_W(CNT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy),
    .obaud_clk(obaud_clk),
    .obaud_cnt(obaud_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // One clock: check outputs at the negedge, drive inputs, advance the model across the next posedge.
  task automatic cyc();
    logic push;
    if (pos >= 0) begin
      chk("tx", {31'd0, tx}, {31'd0, frame_bit(cur, pos / D)});
      chk("cnt", {19'd0, obaud_cnt}, pos % D);
      chk("baud", {31'd0, obaud_clk}, {31'd0, (pos % D) == D - 1});
      chk("busy", {31'd0, busy}, 1);
      if (obaud_clk) pulses++;
    end else begin
      chk("tx_idle", {31'd0, tx}, 1);
      chk("cnt_idle", {19'd0, obaud_cnt}, 0);
      chk("baud_idle", {31'd0, obaud_clk}, 0);
      chk("busy_idle", {31'd0, busy}, {31'd0, fifo_m.size() > 0});
    end
    chk("ready", {31'd0, tx_ready}, {31'd0, fifo_m.size() < DEPTH});
    tx_valid = (stim_q.size() > 0);
    tx_data  = tx_valid ? stim_q[0] : 8'($urandom);
    push = tx_valid && (fifo_m.size() < DEPTH);
    if (pos >= 0 && pos < FL - 1) begin
      pos++;
    end else if (fifo_m.size() > 0) begin
      cur = fifo_m.pop_front();
      pos = 0;
    end else begin
      pos = -1;
    end
    if (push) fifo_m.push_back(stim_q.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tx_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    fifo_m.delete();
    stim_q.delete();
    pos = -1;
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    @(negedge clk);
    do_reset(3);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, tx_ready}, 1);
    chk("rst_cnt", {19'd0, obaud_cnt}, 0);
    run(5);

    // Single byte 0x55: exactly 10 baud pulses, busy drops after the frame
    stim_q.push_back(8'h55);
    pulses = 0;
    run(FL + 10);
    chk("pulses_55", pulses, 10);

    // Four bytes on consecutive cycles, back-to-back frames
    stim_q.push_back(8'hA3);
    stim_q.push_back(8'h00);
    stim_q.push_back(8'hFF);
    stim_q.push_back(8'h37);
    pulses = 0;
    run(4 * FL + 10);
    chk("pulses_4", pulses, 40);

    // Six bytes with valid held: FIFO fills and the last one stalls
    for (int i = 0; i < 6; i++) stim_q.push_back(8'(8'h11 * (i + 1)));
    run(6 * FL + 10);
    chk("stim_drained", stim_q.size(), 0);

    // Reset during data bit 3 of 0x81 with two bytes queued
    stim_q.push_back(8'h81);
    stim_q.push_back(8'h5A);
    stim_q.push_back(8'hC3);
    while (pos != 4 * D + 5) cyc();
    chk("queued_before_rst", fifo_m.size(), 2);
    tx_valid = 1'b0;
    do_reset(1);
    chk("mid_rst_tx", {31'd0, tx}, 1);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_ready", {31'd0, tx_ready}, 1);
    chk("mid_rst_cnt", {19'd0, obaud_cnt}, 0);
    run(FL + 20);

    // Random bytes with random gaps
    for (int i = 0; i < 10; i++) begin
      stim_q.push_back(8'($urandom));
      run($urandom_range(0, 200));
    end
    run(10 * FL + 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
